// File: rtl/mem_read_responder.sv
// rtl/mem_read_responder.sv - pipelined fixed-latency main-memory model for cache miss fills
//
// Purpose:
//   Word-addressed 16-bit memory that accepts one read or write request per clock.
//   Reads return their data on data_out with a one-cycle data_valid pulse exactly
//   LATENCY cycles after the request was sampled. Responses are returned in order,
//   with no backpressure and no stall.
//
// Parameters:
//   LATENCY  cycles from request-sample cycle to data_valid cycle (1..16)
//   ADDR_W   byte-address width; addr[ADDR_W-1:1] selects the word, addr[0] ignored
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset (clears the pipeline, not the array)
//   enable      request strobe
//   wr          request type while enable=1: 1=write, 0=read
//   addr        byte address of the request
//   data_in     write data
//   data_out    returned read data, holds the last returned word while idle
//   data_valid  one-cycle pulse per returned read
//   busy        high while any read is in flight
//   err         (only with MEM_REQ_CHECK_EN) sticky flag for misaligned or X/Z requests
//
// Optional feature macro: MEM_REQ_CHECK_EN

module mem_read_responder #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       data_in,
  output logic [15:0]       data_out,
  output logic              data_valid,
  output logic              busy
`ifdef MEM_REQ_CHECK_EN
  ,
  output logic              err
`endif
);

  localparam int WORDS = 1 << (ADDR_W - 1);

  // Storage has no reset: contents survive rst_n.
  logic [15:0]       mem_q [WORDS];
  logic [ADDR_W-2:0] word_idx;
  logic              rd_issue;
  logic              wr_issue;
  logic [15:0]       rd_word;

  assign word_idx = addr[ADDR_W-1:1];
  assign rd_issue = enable & ~wr;
  assign wr_issue = enable & wr;
  assign rd_word  = mem_q[word_idx];

  always_ff @(posedge clk) begin
    if (wr_issue) begin
      mem_q[word_idx] <= data_in;
    end
  end

  // Read pipeline: stage 0 is loaded at issue, stage LATENCY-1 is the output stage.
  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] valid_d;
  logic [15:0]        data_q [LATENCY];
  logic [15:0]        data_d [LATENCY];

  // A stage's data register only loads when a valid word arrives, so the output
  // stage naturally holds the last returned word across bubbles.
  always_comb begin
    valid_d    = '0;
    valid_d[0] = rd_issue;
    data_d[0]  = rd_issue ? rd_word : data_q[0];
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign data_out   = data_q[LATENCY-1];
  assign data_valid = valid_q[LATENCY-1];
  assign busy       = |valid_q;

`ifdef MEM_REQ_CHECK_EN
  logic err_q;
  logic err_d;
  logic bad_req;

  // Misaligned requests are still serviced; they only raise the sticky flag.
  assign bad_req = enable && (addr[0] || $isunknown({wr, addr}));
  assign err_d   = err_q | bad_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = addr[0];
`endif

endmodule

// File: tb/tb_mem_read_responder.sv
// tb/tb_mem_read_responder.sv - directed self-checking bench for mem_read_responder

module tb_mem_read_responder;

  localparam int LAT = 4;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_valid;
  logic        busy;
`ifdef MEM_REQ_CHECK_EN
  logic        err;
`endif

  int total;
  int bad;

  mem_read_responder #(.LATENCY(LAT), .ADDR_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy)
`ifdef MEM_REQ_CHECK_EN
    ,
    .err        (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    enable  = 1'b1;
    wr      = 1'b1;
    addr    = a;
    data_in = d;
    tick();
    enable  = 1'b0;
    wr      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    enable  = 1'b0;
    wr      = 1'b0;
    addr    = '0;
    data_in = '0;
    repeat (3) tick();
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", data_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL reset_data: got %h want 0000", data_out); end
`ifdef MEM_REQ_CHECK_EN
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    do_write(16'h0010, 16'hA5A5);
    enable = 1'b1; wr = 1'b0; addr = 16'h0010;
    tick();
    enable = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      total++; if (data_valid !== (cyc == 4)) begin bad++; $display("FAIL wr_rd_valid c%0d: got %b want %b", cyc, data_valid, (cyc == 4)); end
      total++; if (busy !== (cyc <= 4)) begin bad++; $display("FAIL wr_rd_busy c%0d: got %b want %b", cyc, busy, (cyc <= 4)); end
      if (cyc == 4) begin
        total++; if (data_out !== 16'hA5A5) begin bad++; $display("FAIL wr_rd_data: got %h want a5a5", data_out); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) do_write(16'h0100 + 16'(2 * i), 16'h1000 + 16'(i));
    for (int c = 0; c < 14; c++) begin
      int cyc;
      enable = (c < 8);
      wr     = 1'b0;
      addr   = 16'h0100 + 16'(2 * c);
      tick();
      cyc = c + 1;
      total++; if (data_valid !== (cyc >= 4 && cyc <= 11)) begin bad++; $display("FAIL burst_valid c%0d: got %b", cyc, data_valid); end
      total++; if (busy !== (cyc >= 1 && cyc <= 11)) begin bad++; $display("FAIL burst_busy c%0d: got %b", cyc, busy); end
      if (cyc >= 4 && cyc <= 11) begin
        total++; if (data_out !== 16'h1000 + 16'(cyc - 4)) begin bad++; $display("FAIL burst_data c%0d: got %h want %h", cyc, data_out, 16'h1000 + 16'(cyc - 4)); end
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_read_then_write();
    do_write(16'h0020, 16'h1111);
    enable = 1'b1; wr = 1'b0; addr = 16'h0020;
    tick();
    enable = 1'b1; wr = 1'b1; addr = 16'h0020; data_in = 16'h2222;
    tick();
    enable = 1'b0; wr = 1'b0;
    tick();
    tick();
    total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL rw_old_valid: got %b want 1", data_valid); end
    total++; if (data_out !== 16'h1111) begin bad++; $display("FAIL rw_old_data: got %h want 1111", data_out); end
    tick();
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL rw_write_slot: got %b want 0", data_valid); end
    enable = 1'b1; wr = 1'b0; addr = 16'h0020;
    tick();
    enable = 1'b0;
    repeat (3) tick();
    total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL rw_new_valid: got %b want 1", data_valid); end
    total++; if (data_out !== 16'h2222) begin bad++; $display("FAIL rw_new_data: got %h want 2222", data_out); end
    tick();
  endtask

  task automatic test_bubbles();
    logic [15:0] hold;
    hold = 16'h2222;
    for (int c = 0; c < 9; c++) begin
      int cyc;
      enable = (c == 0 || c == 2 || c == 3);
      wr     = 1'b0;
      addr   = (c == 0) ? 16'h0100 : (c == 2) ? 16'h0102 : 16'h0104;
      tick();
      cyc = c + 1;
      if (cyc == 4) hold = 16'h1000;
      if (cyc == 6) hold = 16'h1001;
      if (cyc == 7) hold = 16'h1002;
      total++; if (data_valid !== (cyc == 4 || cyc == 6 || cyc == 7)) begin bad++; $display("FAIL bubble_valid c%0d: got %b", cyc, data_valid); end
      total++; if (data_out !== hold) begin bad++; $display("FAIL bubble_data c%0d: got %h want %h", cyc, data_out, hold); end
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_midfill();
    enable = 1'b1; wr = 1'b0; addr = 16'h0100;
    tick();
    addr = 16'h0102;
    tick();
    addr  = 16'h0104;
    rst_n = 1'b0;
    #1;
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", data_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL midrst_data: got %h want 0000", data_out); end
    tick();
    rst_n  = 1'b1;
    enable = 1'b0;
    for (int c = 0; c < 8; c++) begin
      total++; if (data_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_drain c%0d: got valid=%b busy=%b want 0 0", c, data_valid, busy); end
      tick();
    end
    total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL midrst_hold: got %h want 0000", data_out); end
    enable = 1'b1; wr = 1'b0; addr = 16'h0106;
    tick();
    enable = 1'b0;
    repeat (3) tick();
    total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL postrst_valid: got %b want 1", data_valid); end
    total++; if (data_out !== 16'h1003) begin bad++; $display("FAIL postrst_data: got %h want 1003", data_out); end
    tick();
  endtask

  task automatic test_misaligned();
    do_write(16'h0030, 16'h3333);
`ifdef MEM_REQ_CHECK_EN
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_before: got %b want 0", err); end
`endif
    enable = 1'b1; wr = 1'b0; addr = 16'h0031;
    tick();
    enable = 1'b0;
`ifdef MEM_REQ_CHECK_EN
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", err); end
`endif
    repeat (3) tick();
    total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL misalign_valid: got %b want 1", data_valid); end
    total++; if (data_out !== 16'h3333) begin bad++; $display("FAIL misalign_data: got %h want 3333", data_out); end
    repeat (3) tick();
`ifdef MEM_REQ_CHECK_EN
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err); end
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_read_then_write();
    test_bubbles();
    test_reset_midfill();
    test_misaligned();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_read_responder.md
Name: mem_read_responder

Overview:
- Pipelined, fixed-latency main-memory model.
- Serves the memory side of the cache miss-fill path.
- Accepts one read or write request per cycle.
- Each read returns its 16-bit word on data_out, qualified by a one-cycle data_valid pulse, exactly LATENCY cycles after issue.
- Responses are in order, so an 8-word block fill issued back-to-back returns back-to-back.

Parameters:
- LATENCY, 4, cycles from request-sample cycle to data_valid cycle; legal range 1..16.
- ADDR_W, 16, byte-address width; addr[ADDR_W-1:1] indexes 16-bit words, addr[0] ignored.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  request strobe, sampled at rising clk.
- wr  input  1  request type when enable=1: 1=write, 0=read.
- addr  input  ADDR_W  byte address of request.
- data_in  input  16  write data.
- data_out  output  16  read data returned.
- data_valid  output  1  high for one cycle per completed read.
- busy  output  1  high while any read is in flight.

Behaviour:
- Storage:
  - 2^(ADDR_W-1) x 16-bit word array.
  - Contents are NOT cleared by rst_n and persist across reset.
  - Uninitialised words read X.
- Write:
  - enable=1, wr=1 at edge E updates word[addr[ADDR_W-1:1]] at E.
  - A write produces no data_valid and takes no pipeline slot.
  - A read sampled at E+1 returns the new value.
- Read issue:
  - enable=1, wr=0 at edge E reads the array at E.
  - The word plus a valid bit enter stage 0 of a LATENCY-deep shift pipeline.
  - The read value is captured at issue; a later write to the same address does not alter an in-flight read.
- Read return:
  - A request sampled in cycle 0 produces data_valid=1 and data_out=word in cycle LATENCY, for exactly one cycle.
  - With LATENCY=1, the response appears in the cycle immediately after the request.
- Throughput:
  - One request per cycle, no backpressure, no stall.
  - N back-to-back reads produce N consecutive data_valid cycles in issue order.
- Idle cycles:
  - data_valid=0.
  - data_out holds the last returned word; it does not return to 0.
- enable=0 inserts a bubble (valid=0) into the pipeline.
- Mixed requests: a write between reads inserts a bubble in the response stream at the corresponding position.
- busy = OR of all pipeline valid bits; combinational from registered state.
- Reset (async, any time including mid-fill):
  - All pipeline valid bits cleared; data_valid=0, busy=0, data_out=16'h0000.
  - In-flight reads are discarded and never returned.
  - First post-reset request behaves as from idle.
- X on wr or addr while enable=0 has no effect.
- Address wrap: none needed; the array covers the full ADDR_W space.
- State: no FSM.
  - Per-stage state: valid bit plus 16-bit data register.
  - Output stage drives data_out/data_valid directly (registered outputs).

Optional Feature:
- Macro: MEM_REQ_CHECK_EN.
- Defined:
  - Adds output port err (1 bit, reset 0), asserted and held (sticky until rst_n) when either condition occurs:
    - enable=1 with addr[0]=1 (misaligned);
    - enable=1 with wr or addr containing X/Z.
  - A misaligned request is still serviced using addr[ADDR_W-1:1].
- Not defined:
  - Port err and all check logic are absent.
  - Behaviour otherwise identical.

Test Plan:
- Reset, then write 16'hA5A5 to addr 16'h0010, then read 16'h0010 on the next cycle, LATENCY=4 -> data_valid high exactly in cycle 4 after the read, data_out=16'hA5A5; busy high cycles 1-4, low after.
- Preload word addrs 16'h0100..16'h010E (step 2) with 16'h1000..16'h1007; issue 8 reads on consecutive cycles -> 8 consecutive data_valid cycles returning 16'h1000..16'h1007 in order, starting LATENCY cycles after the first read.
- Read 16'h0020 (holding 16'h1111), then write 16'h2222 to 16'h0020 on the next cycle -> returned data is 16'h1111; a subsequent read returns 16'h2222.
- Issue reads in cycles 0, 2, 3 -> data_valid in cycles 4, 6, 7 only; data_out holds its value in cycle 5.
- Issue 3 reads, assert rst_n=0 in cycle 2 for one cycle -> data_valid never asserts for those reads; data_out=16'h0000, busy=0; array contents unchanged on a post-reset read.
- With MEM_REQ_CHECK_EN: read addr 16'h0031 -> err=1 and stays 1; data returned is word at 16'h0030. Without the macro, the same stimulus returns the same data and no err port exists.
